// File: rtl/exception_ctrl.sv
// Exception/ERET sequencer: flush, CP0 update pulse, then fetch redirect.
// Optional EXC_COUNT_EN adds a saturating 16-bit exception-entry counter.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000180
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        WB_VALID,
  input  logic [31:0] WB_PC,
  input  logic        WB_DELAY_SLOT,
  input  logic [5:0]  WB_EXC,
  input  logic [31:0] WB_BAD_VA,
  input  logic        WB_ERET,
  input  logic        INT_COUNTER,
  input  logic [31:0] EPC_Q,
  output logic        E_ENTER,
  output logic        ERET,
  output logic [4:0]  CAUSE,
  output logic [31:0] EPC,
  output logic [31:0] BAD_VA,
  output logic        DELAY_SLOT,
  output logic        FLUSH,
  output logic        REDIRECT_VALID,
  output logic [31:0] REDIRECT_PC,
  input  logic        REDIRECT_READY
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] EXC_COUNT
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ENTER    = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]  state;
  logic        exc_hit;
  logic        ev;
  logic        eret_d;
  logic [4:0]  cause_d;
  logic [31:0] epc_d;
  logic [31:0] bad_d;

  logic        eret_q;
  logic [4:0]  cause_q;
  logic [31:0] epc_q;
  logic [31:0] bad_q;
  logic        ds_q;
  logic        hold_q;
  logic [31:0] pc_hold;
  logic [31:0] pc_live;

  // WB_EXC = {OV, BRK, SYS, RI, ADES, ADEL}
  always_comb begin
    exc_hit = WB_VALID & (|WB_EXC);
    ev      = INT_COUNTER | exc_hit | (WB_VALID & WB_ERET);
    eret_d  = ~INT_COUNTER & ~exc_hit;
    cause_d = 5'd0;
    if (INT_COUNTER)    cause_d = 5'd0;
    else if (WB_EXC[0]) cause_d = 5'd4;
    else if (WB_EXC[1]) cause_d = 5'd5;
    else if (WB_EXC[2]) cause_d = 5'd10;
    else if (WB_EXC[3]) cause_d = 5'd8;
    else if (WB_EXC[4]) cause_d = 5'd9;
    else if (WB_EXC[5]) cause_d = 5'd12;
    epc_d = WB_DELAY_SLOT ? (WB_PC - 32'd4) : WB_PC;
    bad_d = 32'd0;
    if (!INT_COUNTER && WB_VALID && (WB_EXC[0] || WB_EXC[1]))
      bad_d = WB_BAD_VA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      eret_q  <= 1'b0;
      cause_q <= 5'd0;
      epc_q   <= 32'd0;
      bad_q   <= 32'd0;
      ds_q    <= 1'b0;
      hold_q  <= 1'b0;
      pc_hold <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ev) begin
            state   <= ENTER;
            eret_q  <= eret_d;
            cause_q <= eret_d ? 5'd0 : cause_d;
            epc_q   <= epc_d;
            bad_q   <= eret_d ? 32'd0 : bad_d;
            ds_q    <= WB_DELAY_SLOT;
          end
        end
        ENTER: begin
          state  <= REDIRECT;
          hold_q <= 1'b0;
        end
        REDIRECT: begin
          if (REDIRECT_READY) begin
            state  <= IDLE;
            hold_q <= 1'b0;
          end else if (!hold_q) begin
            hold_q  <= 1'b1;
            pc_hold <= pc_live;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EPC_Q is taken in the first redirect cycle and frozen while stalled
  assign pc_live = eret_q ? EPC_Q : EXC_VECTOR;

  always_comb begin
    E_ENTER        = (state == ENTER) & ~eret_q;
    ERET           = (state == ENTER) & eret_q;
    CAUSE          = cause_q;
    EPC            = epc_q;
    BAD_VA         = bad_q;
    DELAY_SLOT     = ds_q;
    REDIRECT_VALID = (state == REDIRECT);
    REDIRECT_PC    = 32'd0;
    if (state == REDIRECT)
      REDIRECT_PC = hold_q ? pc_hold : pc_live;
    FLUSH = RESET_N & ((state != IDLE) | ev);
  end

`ifdef EXC_COUNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      EXC_COUNT <= 16'd0;
    else if (state == ENTER && !eret_q && EXC_COUNT != 16'hFFFF)
      EXC_COUNT <= EXC_COUNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: vector table, random txns vs model, reset cases.
module tb_exception_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_ds;
  logic [5:0]  wb_exc;
  logic [31:0] wb_bva;
  logic        wb_eret;
  logic        int_c;
  logic [31:0] epc_in;
  logic        e_enter;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [31:0] bad_va;
  logic        ds;
  logic        flush;
  logic        rv;
  logic [31:0] rpc;
  logic        ready;
`ifdef EXC_COUNT_EN
  logic [15:0] cnt;
`endif

  exception_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .WB_VALID(wb_valid), .WB_PC(wb_pc),
    .WB_DELAY_SLOT(wb_ds), .WB_EXC(wb_exc), .WB_BAD_VA(wb_bva),
    .WB_ERET(wb_eret), .INT_COUNTER(int_c), .EPC_Q(epc_in),
    .E_ENTER(e_enter), .ERET(eret), .CAUSE(cause), .EPC(epc),
    .BAD_VA(bad_va), .DELAY_SLOT(ds), .FLUSH(flush),
    .REDIRECT_VALID(rv), .REDIRECT_PC(rpc), .REDIRECT_READY(ready)
`ifdef EXC_COUNT_EN
    , .EXC_COUNT(cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        intc;
    logic        valid;
    logic        ds;
    logic        eret;
    logic [5:0]  exc;
    logic [31:0] pc;
    logic [31:0] bva;
    logic [31:0] epcq;
    int          delay;
    logic        ev;
    logic        ee;
    logic        er;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] rpc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int n_ee = 0;
  vec_t tbl[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan causes in priority order, first hit wins.
  function automatic vec_t model(vec_t v);
    int code[6] = '{4, 5, 10, 8, 9, 12};
    vec_t r = v;
    r.ev = 0; r.ee = 0; r.er = 0; r.cause = 0; r.bad = 0;
    if (v.intc) begin
      r.ev = 1; r.ee = 1;
    end else if (v.valid) begin
      for (int k = 0; k < 6; k++)
        if (v.exc[k] && !r.ee) begin
          r.ev = 1; r.ee = 1; r.cause = 5'(code[k]);
          if (k < 2) r.bad = v.bva;
        end
      if (!r.ee && v.eret) begin
        r.ev = 1; r.er = 1;
      end
    end
    r.epc = v.ds ? v.pc - 32'd4 : v.pc;
    r.rpc = r.er ? v.epcq : 32'h180;
    return r;
  endfunction

  task automatic clear_in();
    wb_valid = 0; wb_pc = 0; wb_ds = 0; wb_exc = 0;
    wb_bva = 0; wb_eret = 0; int_c = 0; ready = 0;
  endtask

  task automatic noise();
    wb_valid = 1'($urandom); wb_pc = $urandom; wb_ds = 1'($urandom);
    wb_exc = 6'($urandom); wb_bva = $urandom; wb_eret = 1'($urandom);
    int_c = 1'($urandom);
  endtask

  // Called just after a rising edge with the FSM idle.
  task automatic run_txn(vec_t v);
    int_c = v.intc; wb_valid = v.valid; wb_ds = v.ds; wb_eret = v.eret;
    wb_exc = v.exc; wb_pc = v.pc; wb_bva = v.bva; epc_in = v.epcq;
    ready = 0;
    @(negedge clk);
    chk("flush_n", {31'd0, flush}, {31'd0, v.ev});
    chk("idle_rv", {31'd0, rv}, 32'd0);
    if (v.ev) begin
      @(posedge clk); #1;
      noise();
      ready = 1'($urandom);
      @(negedge clk);
      chk("e_enter", {31'd0, e_enter}, {31'd0, v.ee});
      chk("eret", {31'd0, eret}, {31'd0, v.er});
      if (v.ee) chk("cause", {27'd0, cause}, {27'd0, v.cause});
      chk("epc", epc, v.epc);
      chk("bad_va", bad_va, v.bad);
      chk("delay_slot", {31'd0, ds}, {31'd0, v.ds});
      chk("flush_enter", {31'd0, flush}, 32'd1);
      chk("rv_enter", {31'd0, rv}, 32'd0);
      if (v.ee) n_ee++;
      for (int k = 0; k <= v.delay; k++) begin
        @(posedge clk); #1;
        noise();
        ready = (k == v.delay);
        @(negedge clk);
        chk("rv_hold", {31'd0, rv}, 32'd1);
        chk("rpc", rpc, v.rpc);
        chk("flush_redir", {31'd0, flush}, 32'd1);
        chk("no_pulse", {30'd0, e_enter, eret}, 32'd0);
      end
      @(posedge clk); #1;
      clear_in();
      @(negedge clk);
      chk("back_idle_flush", {31'd0, flush}, 32'd0);
      chk("back_idle_rv", {31'd0, rv}, 32'd0);
      chk("back_idle_rpc", rpc, 32'd0);
    end
    @(posedge clk); #1;
    clear_in();
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001000, 32'h100, 32'h0, 32'h0, 0,
               1'b1, 1'b1, 1'b0, 5'd8, 32'h100, 32'h0, 32'h180};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000001, 32'h0, 32'h3, 32'h0, 1,
               1'b1, 1'b1, 1'b0, 5'd4, 32'hFFFFFFFC, 32'h3, 32'h180};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, 32'h400, 32'h9, 32'h2040, 1,
               1'b1, 1'b0, 1'b1, 5'd0, 32'h400, 32'h0, 32'h2040};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 32'h500, 32'h77, 32'h0, 5,
               1'b1, 1'b1, 1'b0, 5'd0, 32'h500, 32'h0, 32'h180};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b111111, 32'h10, 32'h4, 32'h0, 0,
               1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b100000, 32'h600, 32'h5, 32'h3000, 0,
               1'b1, 1'b1, 1'b0, 5'd12, 32'h600, 32'h0, 32'h180};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001100, 32'h704, 32'h8, 32'h0, 2,
               1'b1, 1'b1, 1'b0, 5'd10, 32'h700, 32'h0, 32'h180};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b010010, 32'h800, 32'hDEAD, 32'h0, 0,
               1'b1, 1'b1, 1'b0, 5'd5, 32'h800, 32'hDEAD, 32'h180};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h900, 32'h1, 32'h0, 0,
               1'b1, 1'b1, 1'b0, 5'd0, 32'h900, 32'h0, 32'h180};

    clear_in();
    epc_in = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pulses", {30'd0, e_enter, eret}, 32'd0);
    chk("rst_rv", {31'd0, rv}, 32'd0);
    chk("rst_rpc", rpc, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      v.intc = ($urandom_range(7) == 0);
      v.valid = 1'($urandom);
      v.ds = 1'($urandom);
      v.eret = 1'($urandom);
      v.exc = 6'($urandom & $urandom & $urandom);
      v.pc = ($urandom_range(3) == 0) ? $urandom_range(7) : $urandom;
      v.bva = $urandom;
      v.epcq = $urandom;
      v.delay = $urandom_range(4);
      run_txn(model(v));
    end

    // Reset in the middle of a stalled redirect
    int_c = 0; wb_valid = 1; wb_exc = 6'b001000; wb_pc = 32'h100;
    @(posedge clk); #1;
    clear_in();
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rv", {31'd0, rv}, 32'd1);
    @(posedge clk); #1;
    int_c = 1; wb_valid = 1; wb_exc = 6'b111111; wb_eret = 1;
    #1 rst_n = 0;
    #1;
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_rv", {31'd0, rv}, 32'd0);
    chk("mid_rst_rpc", rpc, 32'd0);
    chk("mid_rst_pulses", {30'd0, e_enter, eret}, 32'd0);
    chk("mid_rst_cause", {27'd0, cause}, 32'd0);
    chk("mid_rst_bad", bad_va, 32'd0);
`ifdef EXC_COUNT_EN
    chk("mid_rst_count", {16'd0, cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    clear_in();
    ready = 1;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_no_rv", {31'd0, rv}, 32'd0);
      chk("post_rst_no_flush", {31'd0, flush}, 32'd0);
    end

    // First event right after release is taken at the first edge
    rst_n = 0;
    #2;
    int_c = 1;
    #1 rst_n = 1;
    @(posedge clk); #1;
    int_c = 0;
    @(negedge clk);
    chk("first_evt_enter", {31'd0, e_enter}, 32'd1);
    chk("first_evt_cause", {27'd0, cause}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("first_evt_rpc", rpc, 32'h180);
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    chk("first_evt_idle", {31'd0, rv}, 32'd0);
`ifdef EXC_COUNT_EN
    chk("count_after", {16'd0, cnt}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk)
    if (e_enter && eret) begin
      errors++;
      $display("FAIL both_pulses: e_enter=%b eret=%b", e_enter, eret);
    end

endmodule
